// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/RUN/HALT sequencer driving the PC and the IF/ID handoff.
// Optional performance counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  input  logic        halt_in,
  input  logic [8:0]  imem_rdata,
  output logic [7:0]  imem_addr,
  output logic [7:0]  PC_out,
  output logic [8:0]  instr_out,
  output logic        fetch_valid,
  output logic        flush_out,
  output logic        done,
  output logic [15:0] cycle_count,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 9;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;

  // Sequencer: fetch_valid and done are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        RUN: begin
          if (halt_in) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            done        <= 1'b1;
          end else if (branch_taken) begin
            pc <= branch_target;
          end else if (!stall) begin
            pc <= pc + AW'(1);
          end
        end
        HALT: begin
          if (start) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_valid <= 1'b1;
            done        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          pc          <= RESET_PC;
          fetch_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  // Redirect or halt squashes the instruction sitting in IF/ID this very cycle.
  assign flush_out = (state == RUN) && (halt_in || branch_taken);
  assign imem_addr = pc;
  assign PC_out    = pc;
  assign instr_out = fetch_valid ? imem_rdata : IW'(0);

`ifdef FETCH_PERF_CNT_EN
  logic [CW-1:0] cyc_q;
  logic [CW-1:0] fet_q;

  // Saturating counters; cleared by reset and by restart out of HALT.
  always_ff @(posedge CLK) begin
    if (reset || (state == HALT && start)) begin
      cyc_q <= CW'(0);
      fet_q <= CW'(0);
    end else if (state == RUN) begin
      if (cyc_q != {CW{1'b1}}) begin
        cyc_q <= cyc_q + CW'(1);
      end
      if (!stall && !branch_taken && (fet_q != {CW{1'b1}})) begin
        fet_q <= fet_q + CW'(1);
      end
    end
  end

  assign cycle_count = cyc_q;
  assign fetch_count = fet_q;
`else
  assign cycle_count = CW'(0);
  assign fetch_count = CW'(0);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (both counter build options).
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset, start, stall, branch_taken, halt_in;
  logic [7:0]  branch_target;
  logic [8:0]  imem_rdata;
  logic [7:0]  imem_addr, PC_out;
  logic [8:0]  instr_out;
  logic        fetch_valid, flush_out, done;
  logic [15:0] cycle_count, fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .CLK(CLK), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_in(halt_in), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .PC_out(PC_out), .instr_out(instr_out), .fetch_valid(fetch_valid),
    .flush_out(flush_out), .done(done), .cycle_count(cycle_count),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [15:0] ce(input int v);
    return PERF ? 16'(v) : 16'h0000;
  endfunction

  task automatic chk_pc(input string tag, input logic [7:0] exp);
    chk({tag, "_pc"}, 16'(PC_out), 16'(exp));
    chk({tag, "_addr"}, 16'(imem_addr), 16'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int cyc, input int fet);
    chk({tag, "_cyc"}, cycle_count, ce(cyc));
    chk({tag, "_fet"}, fetch_count, ce(fet));
  endtask

  task automatic branch_to(input logic [7:0] t);
    branch_taken = 1'b1; branch_target = t;
    tick();
    branch_taken = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    halt_in = 1'b0; branch_target = 8'h00; imem_rdata = 9'h1A5;
    tick(); tick();
    reset = 1'b0; #1;

    // Reset state
    chk_pc("rst", 8'h00);
    chk("rst_fv", 16'(fetch_valid), 16'h0);
    chk("rst_flush", 16'(flush_out), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_instr", 16'(instr_out), 16'h000);
    chk_cnt("rst", 0, 0);

    // Start and free-run
    start = 1'b1; tick(); start = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk_pc($sformatf("run%0d", i), 8'(i));
      chk($sformatf("run%0d_fv", i), 16'(fetch_valid), 16'h1);
      chk($sformatf("run%0d_instr", i), 16'(instr_out), 16'h1A5);
      if (i < 3) tick();
    end
    chk_cnt("run3", 3, 3);

    // Branch wins over stall
    branch_to(8'h10);
    chk_pc("br10", 8'h10);
    branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1; #1;
    chk("br_stall_flush", 16'(flush_out), 16'h1);
    tick(); branch_taken = 1'b0; stall = 1'b0; #1;
    chk_pc("br40", 8'h40);
    chk_cnt("br40", 5, 3);

    // Stall holds PC
    branch_to(8'h05);
    stall = 1'b1; #1;
    chk("stall_flush", 16'(flush_out), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pc($sformatf("stall%0d", i), 8'h05);
      chk($sformatf("stall%0d_fv", i), 16'(fetch_valid), 16'h1);
    end
    stall = 1'b0; #1;
    chk_cnt("stall", 9, 3);

    // PC wrap
    branch_to(8'hFF);
    chk_pc("ff", 8'hFF);
    tick(); #1;
    chk_pc("wrap", 8'h00);
    chk("wrap_fv", 16'(fetch_valid), 16'h1);
    chk_cnt("wrap", 11, 4);

    // Halt and restart
    branch_to(8'h22);
    halt_in = 1'b1; #1;
    chk("halt_flush", 16'(flush_out), 16'h1);
    tick(); halt_in = 1'b0; #1;
    chk("halt_done", 16'(done), 16'h1);
    chk_pc("halt", 8'h22);
    chk("halt_fv", 16'(fetch_valid), 16'h0);
    chk("halt_instr", 16'(instr_out), 16'h000);
    chk_cnt("halt", 13, 5);
    branch_taken = 1'b1; branch_target = 8'h77; stall = 1'b1; #1;
    chk("halt_ign_flush", 16'(flush_out), 16'h0);
    tick(); branch_taken = 1'b0; stall = 1'b0; #1;
    chk_pc("halt_ign", 8'h22);
    chk_cnt("halt_hold", 13, 5);
    start = 1'b1; tick(); start = 1'b0; #1;
    chk_pc("restart", 8'h00);
    chk("restart_done", 16'(done), 16'h0);
    chk("restart_fv", 16'(fetch_valid), 16'h1);
    chk_cnt("restart", 0, 0);

    // Reset overrides start/branch mid-RUN
    branch_to(8'h30);
    chk_pc("pre_rst", 8'h30);
    reset = 1'b1; start = 1'b1; branch_taken = 1'b1; branch_target = 8'h99;
    tick();
    reset = 1'b0; start = 1'b0; branch_taken = 1'b0; #1;
    chk_pc("mrst", 8'h00);
    chk("mrst_fv", 16'(fetch_valid), 16'h0);
    chk("mrst_done", 16'(done), 16'h0);
    chk("mrst_flush", 16'(flush_out), 16'h0);
    chk("mrst_instr", 16'(instr_out), 16'h000);
    chk_cnt("mrst", 0, 0);

    // IDLE ignores branch/stall
    branch_taken = 1'b1; branch_target = 8'h55; #1;
    chk("idle_flush", 16'(flush_out), 16'h0);
    tick(); branch_taken = 1'b0; #1;
    chk_pc("idle", 8'h00);
    chk("idle_fv", 16'(fetch_valid), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
